// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data RAM: one RISC-V load/store
// per three-cycle transaction (IDLE -> ACCESS -> RESP), with lane steering and load formatting.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_valid,
  output logic [1:0]        m_ready,
  input  logic [63:0]       m_addr,
  input  logic [1:0]        m_we,
  input  logic [5:0]        m_funct3,
  input  logic [63:0]       m_wdata,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        last_grant;
  logic        grant_d;
  logic        accept;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic        legal_f3;
  logic        misalign;
  logic        err;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        unused_addr;

  // Only the word-address bits reach the RAM; the rest of the latched address is dropped.
  assign unused_addr = ^addr_q[31:MEM_AW+2];

  // Round-robin on ties: the requester that did not win last time goes first.
  always_comb begin
    grant_d = 1'b0;
    case (m_valid)
      2'b01:   grant_d = 1'b0;
      2'b10:   grant_d = 1'b1;
      2'b11:   grant_d = ~last_grant;
      default: grant_d = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && (|m_valid);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|m_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload is captured once at acceptance, so requesters may change inputs afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      last_grant <= grant_d;
      addr_q     <= grant_d ? m_addr[63:32]    : m_addr[31:0];
      we_q       <= grant_d ? m_we[1]          : m_we[0];
      funct3_q   <= grant_d ? m_funct3[5:3]    : m_funct3[2:0];
      wdata_q    <= grant_d ? m_wdata[63:32]   : m_wdata[31:0];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    legal_f3   = 1'b0;
    misalign   = 1'b0;
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    if (we_q) legal_f3 = (funct3_q[2] == 1'b0) && (funct3_q[1:0] != 2'b11);
    else      legal_f3 = (funct3_q[1:0] != 2'b11) && (funct3_q != 3'b110);
    case (funct3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        misalign   = addr_q[0];
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: misalign = (addr_q[1:0] != 2'b00);
    endcase
  end

  assign err = !legal_f3 || misalign;

  always_comb begin
    shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // m_ready is gated by rst directly so it is 0 for the whole reset window.
  always_comb begin
    m_ready   = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (rst && (|m_valid)) m_ready[grant_d] = 1'b1;
      ACCESS: if (!err) begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = lane_be;
        mem_addr  = addr_q[MEM_AW+1:2];
        mem_wdata = we_q ? lane_wdata : 32'b0;
      end
      RESP: begin
        rsp_valid[last_grant] = 1'b1;
        rsp_err               = err;
        rsp_rdata             = (err || we_q) ? 32'b0 : load_data;
      end
      default: ;
    endcase
  end

endmodule
